// File: rtl/cv32e40x_wb_ctrl.sv
// Write-back stage controller: one instruction slot, ALU retire plus LSU response
// wait, load alignment and sign extension. CV32E40X_WB_PERF_EN enables the wait-cycle counter.
module cv32e40x_wb_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int RF_ADDR_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid_i,
    output logic                     wb_ready_o,
    input  logic                     ex_rf_we_i,
    input  logic [RF_ADDR_WIDTH-1:0] ex_rf_waddr_i,
    input  logic [DATA_WIDTH-1:0]    ex_rf_wdata_i,
    input  logic                     ex_data_req_i,
    input  logic                     ex_data_we_i,
    input  logic [1:0]               ex_lsu_size_i,
    input  logic                     ex_lsu_sext_i,
    input  logic [1:0]               ex_addr_lsb_i,
    input  logic                     ex_split_i,
    input  logic                     data_rvalid_i,
    input  logic [DATA_WIDTH-1:0]    data_rdata_i,
    input  logic                     data_err_i,
    input  logic                     kill_wb_i,
    output logic                     rf_we_wb_o,
    output logic [RF_ADDR_WIDTH-1:0] rf_waddr_wb_o,
    output logic                     data_req_wb_o,
    output logic                     rf_we_o,
    output logic [DATA_WIDTH-1:0]    rf_wdata_o,
    output logic                     wb_retire_o,
    output logic                     lsu_err_o,
    output logic [31:0]              perf_wb_wait_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_LO = 2'd1,
        WAIT_HI = 2'd2
    } wb_state_e;

    wb_state_e                state_q, state_d;
    logic                     slot_valid_q, slot_valid_d;
    logic                     rf_we_q, rf_we_d;
    logic [RF_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     data_req_q, data_req_d;
    logic                     data_we_q, data_we_d;
    logic [1:0]               size_q, size_d;
    logic                     sext_q, sext_d;
    logic [1:0]               lsb_q, lsb_d;
    logic                     split_q, split_d;
    logic [DATA_WIDTH-1:0]    hold_lo_q, hold_lo_d;
    logic                     err_q, err_d;
    logic                     killed_q, killed_d;

    logic                     retire_now_s;
    logic                     killed_s;
    logic                     err_final_s;
    logic                     wb_ready_s;
    logic                     accept_s;
    logic [DATA_WIDTH-1:0]    lo_word_s;
    logic [DATA_WIDTH-1:0]    shifted_s;
    logic [DATA_WIDTH-1:0]    load_data_s;

    // State register: slot contents, FSM state and sticky error/kill flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            slot_valid_q <= 1'b0;
            rf_we_q      <= 1'b0;
            waddr_q      <= {RF_ADDR_WIDTH{1'b0}};
            wdata_q      <= {DATA_WIDTH{1'b0}};
            data_req_q   <= 1'b0;
            data_we_q    <= 1'b0;
            size_q       <= 2'd0;
            sext_q       <= 1'b0;
            lsb_q        <= 2'd0;
            split_q      <= 1'b0;
            hold_lo_q    <= {DATA_WIDTH{1'b0}};
            err_q        <= 1'b0;
            killed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            rf_we_q      <= rf_we_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            data_req_q   <= data_req_d;
            data_we_q    <= data_we_d;
            size_q       <= size_d;
            sext_q       <= sext_d;
            lsb_q        <= lsb_d;
            split_q      <= split_d;
            hold_lo_q    <= hold_lo_d;
            err_q        <= err_d;
            killed_q     <= killed_d;
        end
    end

    // Slot status: retirement, handshake and effective kill/error
    always_comb begin
        killed_s    = killed_q | kill_wb_i;
        err_final_s = err_q | data_err_i;
        if (data_req_q) begin
            retire_now_s = slot_valid_q && (state_q == WAIT_HI) && data_rvalid_i;
        end else begin
            retire_now_s = slot_valid_q;
        end
        wb_ready_s = !slot_valid_q || retire_now_s;
        accept_s   = ex_valid_i && wb_ready_s;
    end

    // Next-state: accept from EX, retire, or advance through the response wait
    always_comb begin
        state_d      = state_q;
        slot_valid_d = slot_valid_q;
        rf_we_d      = rf_we_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        data_req_d   = data_req_q;
        data_we_d    = data_we_q;
        size_d       = size_q;
        sext_d       = sext_q;
        lsb_d        = lsb_q;
        split_d      = split_q;
        hold_lo_d    = hold_lo_q;
        err_d        = err_q;
        killed_d     = killed_q;
        if (accept_s) begin
            slot_valid_d = 1'b1;
            rf_we_d      = ex_rf_we_i;
            waddr_d      = ex_rf_waddr_i;
            wdata_d      = ex_rf_wdata_i;
            data_req_d   = ex_data_req_i;
            data_we_d    = ex_data_we_i;
            size_d       = ex_lsu_size_i;
            sext_d       = ex_lsu_sext_i;
            lsb_d        = ex_addr_lsb_i;
            split_d      = ex_split_i;
            err_d        = 1'b0;
            killed_d     = 1'b0;
            if (ex_data_req_i) begin
                state_d = ex_split_i ? WAIT_LO : WAIT_HI;
            end else begin
                state_d = IDLE;
            end
        end else if (retire_now_s) begin
            // A killed ALU slot also lands here: it is dropped without a write
            slot_valid_d = 1'b0;
            state_d      = IDLE;
            err_d        = 1'b0;
            killed_d     = 1'b0;
        end else if (slot_valid_q && data_req_q) begin
            killed_d = killed_s;
            if ((state_q == WAIT_LO) && data_rvalid_i) begin
                hold_lo_d = data_rdata_i;
                err_d     = err_q | data_err_i;
                state_d   = WAIT_HI;
            end else begin
                state_d = state_q;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Load alignment across the two response words, then size/sign extraction
    always_comb begin
        lo_word_s = split_q ? hold_lo_q : data_rdata_i;
        case (lsb_q)
            2'd0:    shifted_s = lo_word_s;
            2'd1:    shifted_s = {data_rdata_i[7:0],  lo_word_s[31:8]};
            2'd2:    shifted_s = {data_rdata_i[15:0], lo_word_s[31:16]};
            2'd3:    shifted_s = {data_rdata_i[23:0], lo_word_s[31:24]};
            default: shifted_s = lo_word_s;
        endcase
        case (size_q)
            2'd0:    load_data_s = sext_q ? {{24{shifted_s[7]}}, shifted_s[7:0]}
                                          : {24'h0, shifted_s[7:0]};
            2'd1:    load_data_s = sext_q ? {{16{shifted_s[15]}}, shifted_s[15:0]}
                                          : {16'h0, shifted_s[15:0]};
            default: load_data_s = shifted_s;
        endcase
    end

    // Outputs: RF write port, retire/error pulses and bypass-side slot view
    always_comb begin
        wb_ready_o    = wb_ready_s;
        wb_retire_o   = retire_now_s && !killed_s;
        rf_we_wb_o    = slot_valid_q && rf_we_q;
        data_req_wb_o = slot_valid_q && data_req_q;
        rf_waddr_wb_o = slot_valid_q ? waddr_q : {RF_ADDR_WIDTH{1'b0}};
        if (data_req_q) begin
            rf_we_o    = retire_now_s && !killed_s && rf_we_q && !data_we_q && !err_final_s;
            lsu_err_o  = retire_now_s && !killed_s && err_final_s;
            rf_wdata_o = load_data_s;
        end else begin
            rf_we_o    = retire_now_s && !killed_s && rf_we_q;
            lsu_err_o  = 1'b0;
            rf_wdata_o = wdata_q;
        end
    end

`ifdef CV32E40X_WB_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;

    // Saturating count of cycles spent waiting on an LSU response
    always_comb begin
        if (slot_valid_q && (state_q != IDLE) && !data_rvalid_i && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end else begin
            perf_cnt_d = perf_cnt_q;
        end
    end

    // Wait-cycle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= 32'h0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_wb_wait_cnt_o = perf_cnt_q;
`else
    assign perf_wb_wait_cnt_o = 32'h0;
`endif

    cv32e40x_wb_ctrl_sva u_sva (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_rvalid_i (data_rvalid_i),
        .lsu_wait_i    (slot_valid_q && (state_q != IDLE))
    );

endmodule

// Protocol checks: OBI responses only arrive while an LSU slot is waiting.
module cv32e40x_wb_ctrl_sva (
    input logic clk,
    input logic rst_n,
    input logic data_rvalid_i,
    input logic lsu_wait_i
);

    a_no_rvalid_idle: assert property (@(posedge clk) disable iff (!rst_n)
        data_rvalid_i |-> lsu_wait_i);

endmodule

// File: tb/tb_cv32e40x_wb_ctrl.sv
// Self-checking bench for cv32e40x_wb_ctrl: scoreboard of expected retirements
// plus per-scenario checks of handshake, bypass and kill behaviour.
module tb_cv32e40x_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ex_valid_i;
    logic        wb_ready_o;
    logic        ex_rf_we_i;
    logic [4:0]  ex_rf_waddr_i;
    logic [31:0] ex_rf_wdata_i;
    logic        ex_data_req_i;
    logic        ex_data_we_i;
    logic [1:0]  ex_lsu_size_i;
    logic        ex_lsu_sext_i;
    logic [1:0]  ex_addr_lsb_i;
    logic        ex_split_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic        kill_wb_i;
    logic        rf_we_wb_o;
    logic [4:0]  rf_waddr_wb_o;
    logic        data_req_wb_o;
    logic        rf_we_o;
    logic [31:0] rf_wdata_o;
    logic        wb_retire_o;
    logic        lsu_err_o;
    logic [31:0] perf_wb_wait_cnt_o;

    typedef struct packed {
        logic        we;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    cv32e40x_wb_ctrl #(.DATA_WIDTH(32), .RF_ADDR_WIDTH(5)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .ex_valid_i         (ex_valid_i),
        .wb_ready_o         (wb_ready_o),
        .ex_rf_we_i         (ex_rf_we_i),
        .ex_rf_waddr_i      (ex_rf_waddr_i),
        .ex_rf_wdata_i      (ex_rf_wdata_i),
        .ex_data_req_i      (ex_data_req_i),
        .ex_data_we_i       (ex_data_we_i),
        .ex_lsu_size_i      (ex_lsu_size_i),
        .ex_lsu_sext_i      (ex_lsu_sext_i),
        .ex_addr_lsb_i      (ex_addr_lsb_i),
        .ex_split_i         (ex_split_i),
        .data_rvalid_i      (data_rvalid_i),
        .data_rdata_i       (data_rdata_i),
        .data_err_i         (data_err_i),
        .kill_wb_i          (kill_wb_i),
        .rf_we_wb_o         (rf_we_wb_o),
        .rf_waddr_wb_o      (rf_waddr_wb_o),
        .data_req_wb_o      (data_req_wb_o),
        .rf_we_o            (rf_we_o),
        .rf_wdata_o         (rf_wdata_o),
        .wb_retire_o        (wb_retire_o),
        .lsu_err_o          (lsu_err_o),
        .perf_wb_wait_cnt_o (perf_wb_wait_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumer: every retirement event must match the oldest expectation
    always begin
        @(negedge clk);
        #2;
        if (rst_n && (wb_retire_o || rf_we_o || lsu_err_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_retire: unexpected retire=%0b rf_we=%0b err=%0b wdata=%h, required no event",
                         wb_retire_o, rf_we_o, lsu_err_o, rf_wdata_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (wb_retire_o !== 1'b1 || rf_we_o !== e.we || lsu_err_o !== e.err ||
                    (e.we && rf_wdata_o !== e.wdata)) begin
                    failures++;
                    $display("FAIL sb_retire: got retire=%0b we=%0b err=%0b wdata=%h, required retire=1 we=%0b err=%0b wdata=%h",
                             wb_retire_o, rf_we_o, lsu_err_o, rf_wdata_o, e.we, e.err, e.wdata);
                end
            end
        end
    end

    task automatic drive_ex(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                            input logic req, input logic dwe, input logic [1:0] size,
                            input logic sext, input logic [1:0] lsb, input logic split);
        ex_valid_i    = 1'b1;
        ex_rf_we_i    = we;
        ex_rf_waddr_i = addr;
        ex_rf_wdata_i = wdata;
        ex_data_req_i = req;
        ex_data_we_i  = dwe;
        ex_lsu_size_i = size;
        ex_lsu_sext_i = sext;
        ex_addr_lsb_i = lsb;
        ex_split_i    = split;
    endtask

    task automatic clear_ex();
        ex_valid_i    = 1'b0;
        ex_rf_we_i    = 1'b0;
        ex_rf_waddr_i = 5'd0;
        ex_rf_wdata_i = 32'h0;
        ex_data_req_i = 1'b0;
        ex_data_we_i  = 1'b0;
        ex_lsu_size_i = 2'd0;
        ex_lsu_sext_i = 1'b0;
        ex_addr_lsb_i = 2'd0;
        ex_split_i    = 1'b0;
    endtask

    task automatic resp(input logic v, input logic [31:0] d, input logic e);
        data_rvalid_i = v;
        data_rdata_i  = d;
        data_err_i    = e;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_ex();
        resp(1'b0, 32'h0, 1'b0);
        kill_wb_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({wb_ready_o, rf_we_o, rf_we_wb_o, data_req_wb_o, wb_retire_o, lsu_err_o} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got ready/we/we_wb/req_wb/retire/err=%b, required 100000",
                     {wb_ready_o, rf_we_o, rf_we_wb_o, data_req_wb_o, wb_retire_o, lsu_err_o});
        end
        checks++;
        if (rf_wdata_o !== 32'h0 || rf_waddr_wb_o !== 5'd0 || perf_wb_wait_cnt_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_data: got wdata=%h waddr=%0d perf=%0d, required 0/0/0",
                     rf_wdata_o, rf_waddr_wb_o, perf_wb_wait_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [4:0]  addr [4];
        logic [31:0] data [4];
        logic        we   [4];
        addr = '{5'd5, 5'd6, 5'd7, 5'd0};
        data = '{32'h0000_1234, 32'h0000_5678, $urandom, $urandom};
        we   = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                drive_ex(we[i], addr[i], data[i], 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
                exp_q.push_back('{we[i], data[i], 1'b0});
            end else begin
                clear_ex();
            end
            #1;
            checks++;
            if (wb_ready_o !== 1'b1) begin
                failures++;
                $display("FAIL b2b_ready: cycle %0d got wb_ready=%0b, required 1", i, wb_ready_o);
            end
            if (i > 0) begin
                checks++;
                if (rf_we_wb_o !== we[i-1] || rf_waddr_wb_o !== addr[i-1]) begin
                    failures++;
                    $display("FAIL b2b_bypass: cycle %0d got we_wb=%0b waddr=%0d, required %0b/%0d",
                             i, rf_we_wb_o, rf_waddr_wb_o, we[i-1], addr[i-1]);
                end
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || rf_we_wb_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: got pending=%0d we_wb=%0b, required 0/0", exp_q.size(), rf_we_wb_o);
        end
    endtask

    task automatic test_load_aligned();
        logic [31:0] exp_perf;
        @(negedge clk);
        drive_ex(1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
        exp_q.push_back('{1'b1, 32'hFFFF_FF80, 1'b0});
        @(negedge clk);
        clear_ex();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (wb_ready_o !== 1'b0 || rf_we_wb_o !== 1'b1 || data_req_wb_o !== 1'b1 || rf_waddr_wb_o !== 5'd7) begin
                failures++;
                $display("FAIL lb_wait: wait %0d got ready=%0b we_wb=%0b req_wb=%0b waddr=%0d, required 0/1/1/7",
                         i, wb_ready_o, rf_we_wb_o, data_req_wb_o, rf_waddr_wb_o);
            end
            @(negedge clk);
        end
        resp(1'b1, 32'h80FF_FFFF, 1'b0);
        #1;
`ifdef CV32E40X_WB_PERF_EN
        exp_perf = 32'd2;
`else
        exp_perf = 32'd0;
`endif
        checks++;
        if (wb_ready_o !== 1'b1 || perf_wb_wait_cnt_o !== exp_perf) begin
            failures++;
            $display("FAIL lb_resp: got ready=%0b perf=%0d, required 1/%0d", wb_ready_o, perf_wb_wait_cnt_o, exp_perf);
        end
        @(negedge clk);
        resp(1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL lb_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_load_sizes();
        logic [1:0]  sz   [4];
        logic        sx   [4];
        logic [1:0]  lsb  [4];
        logic [31:0] rd   [4];
        logic [31:0] expd [4];
        sz   = '{2'd1, 2'd1, 2'd0, 2'd2};
        sx   = '{1'b1, 1'b0, 1'b0, 1'b1};
        lsb  = '{2'd2, 2'd0, 2'd1, 2'd0};
        rd   = '{32'h8001_1234, 32'h1234_F00D, 32'h0000_AB00, 32'hDEAD_BEEF};
        expd = '{32'hFFFF_8001, 32'h0000_F00D, 32'h0000_00AB, 32'hDEAD_BEEF};
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i < 4) begin
                drive_ex(1'b1, 5'(i + 12), 32'h0, 1'b1, 1'b0, sz[i], sx[i], lsb[i], 1'b0);
                exp_q.push_back('{1'b1, expd[i], 1'b0});
            end else begin
                clear_ex();
            end
            if (i > 0) begin
                resp(1'b1, rd[i-1], 1'b0);
            end else begin
                resp(1'b0, 32'h0, 1'b0);
            end
            #1;
            if (i > 0) begin
                checks++;
                if (wb_ready_o !== 1'b1) begin
                    failures++;
                    $display("FAIL ld_b2b_ready: cycle %0d got wb_ready=%0b, required 1", i, wb_ready_o);
                end
            end
        end
        @(negedge clk);
        resp(1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL ld_sizes_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_split_lw();
        @(negedge clk);
        drive_ex(1'b1, 5'd8, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd2, 1'b1);
        exp_q.push_back('{1'b1, 32'h3344_AABB, 1'b0});
        @(negedge clk);
        clear_ex();
        resp(1'b1, 32'hAABB_CCDD, 1'b0);
        #1;
        checks++;
        if (wb_ready_o !== 1'b0 || wb_retire_o !== 1'b0) begin
            failures++;
            $display("FAIL split_first: got ready=%0b retire=%0b, required 0/0", wb_ready_o, wb_retire_o);
        end
        @(negedge clk);
        resp(1'b1, 32'h1122_3344, 1'b0);
        #1;
        checks++;
        if (wb_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL split_final: got ready=%0b, required 1", wb_ready_o);
        end
        @(negedge clk);
        resp(1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (exp_q.size() != 0 || data_req_wb_o !== 1'b0) begin
            failures++;
            $display("FAIL split_drain: got pending=%0d req_wb=%0b, required 0/0", exp_q.size(), data_req_wb_o);
        end
    endtask

    task automatic test_split_err();
        @(negedge clk);
        drive_ex(1'b1, 5'd9, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 2'd3, 1'b1);
        exp_q.push_back('{1'b0, 32'h0, 1'b1});
        @(negedge clk);
        clear_ex();
        resp(1'b1, 32'h5555_5555, 1'b1);
        #1;
        checks++;
        if (wb_retire_o !== 1'b0 || lsu_err_o !== 1'b0) begin
            failures++;
            $display("FAIL err_first: got retire=%0b err=%0b, required 0/0", wb_retire_o, lsu_err_o);
        end
        @(negedge clk);
        resp(1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (wb_ready_o !== 1'b0 || rf_we_wb_o !== 1'b1) begin
            failures++;
            $display("FAIL err_wait: got ready=%0b we_wb=%0b, required 0/1", wb_ready_o, rf_we_wb_o);
        end
        @(negedge clk);
        resp(1'b1, 32'h6666_6666, 1'b0);
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || lsu_err_o !== 1'b1 || wb_retire_o !== 1'b1) begin
            failures++;
            $display("FAIL err_final: got we=%0b err=%0b retire=%0b, required 0/1/1", rf_we_o, lsu_err_o, wb_retire_o);
        end
        @(negedge clk);
        resp(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_kill_alu();
        @(negedge clk);
        drive_ex(1'b1, 5'd9, 32'hCAFE_0001, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        clear_ex();
        kill_wb_i = 1'b1;
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || wb_retire_o !== 1'b0 || wb_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL kill_alu: got we=%0b retire=%0b ready=%0b, required 0/0/1", rf_we_o, wb_retire_o, wb_ready_o);
        end
        @(negedge clk);
        kill_wb_i = 1'b0;
        #1;
        checks++;
        if (rf_we_wb_o !== 1'b0 || wb_retire_o !== 1'b0) begin
            failures++;
            $display("FAIL kill_alu_clear: got we_wb=%0b retire=%0b, required 0/0", rf_we_wb_o, wb_retire_o);
        end
    endtask

    task automatic test_kill_load();
        @(negedge clk);
        drive_ex(1'b1, 5'd10, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        clear_ex();
        kill_wb_i = 1'b1;
        #1;
        checks++;
        if (wb_ready_o !== 1'b0 || rf_we_wb_o !== 1'b1) begin
            failures++;
            $display("FAIL kill_ld_hold: got ready=%0b we_wb=%0b, required 0/1", wb_ready_o, rf_we_wb_o);
        end
        @(negedge clk);
        kill_wb_i = 1'b0;
        @(negedge clk);
        resp(1'b1, 32'h1357_9BDF, 1'b1);
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || wb_retire_o !== 1'b0 || lsu_err_o !== 1'b0 || wb_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL kill_ld_resp: got we=%0b retire=%0b err=%0b ready=%0b, required 0/0/0/1",
                     rf_we_o, wb_retire_o, lsu_err_o, wb_ready_o);
        end
        @(negedge clk);
        resp(1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (data_req_wb_o !== 1'b0) begin
            failures++;
            $display("FAIL kill_ld_clear: got req_wb=%0b, required 0", data_req_wb_o);
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        drive_ex(1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        exp_q.push_back('{1'b0, 32'h0, 1'b0});
        @(negedge clk);
        clear_ex();
        resp(1'b1, 32'hFFFF_FFFF, 1'b0);
        #1;
        checks++;
        if (rf_we_o !== 1'b0 || wb_retire_o !== 1'b1) begin
            failures++;
            $display("FAIL store: got we=%0b retire=%0b, required 0/1", rf_we_o, wb_retire_o);
        end
        @(negedge clk);
        resp(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        drive_ex(1'b1, 5'd11, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        clear_ex();
        @(negedge clk);
        #1;
        checks++;
        if (rf_we_wb_o !== 1'b1 || wb_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre: got we_wb=%0b ready=%0b, required 1/0", rf_we_wb_o, wb_ready_o);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_ready_o, rf_we_o, rf_we_wb_o, data_req_wb_o, wb_retire_o, lsu_err_o} !== 6'b100000 ||
            rf_waddr_wb_o !== 5'd0 || perf_wb_wait_cnt_o !== 32'h0) begin
            failures++;
            $display("FAIL rst_mid: got ready/we/we_wb/req_wb/retire/err=%b waddr=%0d perf=%0d, required 100000/0/0",
                     {wb_ready_o, rf_we_o, rf_we_wb_o, data_req_wb_o, wb_retire_o, lsu_err_o},
                     rf_waddr_wb_o, perf_wb_wait_cnt_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        drive_ex(1'b1, 5'd12, 32'h0000_CAFE, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
        exp_q.push_back('{1'b1, 32'h0000_CAFE, 1'b0});
        @(negedge clk);
        clear_ex();
        #1;
        checks++;
        if (rf_we_o !== 1'b1 || rf_wdata_o !== 32'h0000_CAFE) begin
            failures++;
            $display("FAIL rst_alu: got we=%0b wdata=%h, required 1/0000cafe", rf_we_o, rf_wdata_o);
        end
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rst_drain: got pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_load_aligned();
        test_load_sizes();
        test_split_lw();
        test_split_err();
        test_kill_alu();
        test_kill_load();
        test_store();
        test_reset_mid_wait();
        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
